plan_activation: RTL and testbench

//  Parametrised PLAN (piecewise-linear approximation) activation unit: sigmoid or

---
 rtl/plan_activation_if.sv | 23 ++
 rtl/plan_activation.sv | 137 +++++++++++++
 tb/tb_plan_activation.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/plan_activation_if.sv
// Valid/ready bundle for the PLAN activation unit.
// Operand side flows in, result side flows out.
interface plan_activation_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [N-1:0] x_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;

    modport master (
        output in_valid, mode, x_in, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, mode, x_in, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/plan_activation.sv
// PLAN piecewise-linear sigmoid/tanh, one op in flight.
// Q(N-FRAC).FRAC signed fixed point, one FSM state per pipeline step.
module plan_activation #(
    parameter int N    = 32,
    parameter int FRAC = 16
) (
    input logic              clk,
    input logic              rst,
    plan_activation_if.slave bus
);

    if ((FRAC < 5) || (N - FRAC < 5)) begin : g_bad_params
        $error("plan_activation: need FRAC>=5 and N-FRAC>=5");
    end

    localparam logic [N-1:0] ONE   = N'(1) << FRAC;
    localparam logic [N-1:0] FIVE  = N'(5) << FRAC;
    localparam logic [N-1:0] T2375 = N'(19) << (FRAC - 3);
    localparam logic [N-1:0] C844  = N'(27) << (FRAC - 5);
    localparam logic [N-1:0] C625  = N'(5) << (FRAC - 3);
    localparam logic [N-1:0] HALF  = N'(1) << (FRAC - 1);
    localparam logic [N-1:0] MIN   = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_SEG,
        S_SYM,
        S_MAP,
        S_OUT
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] x_q, x_d;
    logic         mode_q, mode_d;
    logic         s_q, s_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] y_q, y_d;
    logic [N-1:0] sig_q, sig_d;
    logic [N-1:0] out_q, out_d;

    logic [N-1:0] z;
    logic         ovf;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        mode_d  = mode_q;
        s_d     = s_q;
        a_d     = a_q;
        y_d     = y_q;
        sig_d   = sig_q;
        out_d   = out_q;
        // doubling for tanh overflows exactly when the top two bits differ
        ovf     = mode_q && (x_q[N-1] ^ x_q[N-2]);
        z       = mode_q ? (x_q + x_q) : x_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.x_in;
                    mode_d  = bus.mode;
                    state_d = S_ABS;
                end
            end
            S_ABS: begin
                if (ovf) begin
                    s_d = x_q[N-1];
                    a_d = FIVE;
                end else begin
                    s_d = z[N-1];
                    if (z == MIN) begin
                        a_d = FIVE;
                    end else begin
                        a_d = z[N-1] ? -z : z;
                    end
                end
                state_d = S_SEG;
            end
            S_SEG: begin
                if (a_q >= FIVE) begin
                    y_d = ONE;
                end else if (a_q >= T2375) begin
                    y_d = (a_q >> 5) + C844;
                end else if (a_q >= ONE) begin
                    y_d = (a_q >> 3) + C625;
                end else begin
                    y_d = (a_q >> 2) + HALF;
                end
                state_d = S_SYM;
            end
            S_SYM: begin
                sig_d   = s_q ? (ONE - y_q) : y_q;
                state_d = S_MAP;
            end
            S_MAP: begin
                out_d   = mode_q ? (sig_q + sig_q - ONE) : sig_q;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            mode_q  <= 1'b0;
            s_q     <= 1'b0;
            a_q     <= '0;
            y_q     <= '0;
            sig_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            mode_q  <= mode_d;
            s_q     <= s_d;
            a_q     <= a_d;
            y_q     <= y_d;
            sig_q   <= sig_d;
            out_q   <= out_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out       = out_q;

endmodule

// File: tb/tb_plan_activation.sv
// Randomized bench for plan_activation against a wide-integer
// model of the PLAN segment rules.
module tb_plan_activation;

    localparam int N    = 32;
    localparam int FRAC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    plan_activation_if #(.N(N)) bus ();

    plan_activation #(.N(N), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // 64-bit arithmetic: doubling never wraps, so huge |z| lands in the 1.0 segment
    function automatic logic [31:0] model(input logic [31:0] x, input logic m);
        longint one, z, a, y, sig, res;
        one = 64'sd1 << FRAC;
        z   = longint'($signed(x));
        if (m) z = 2 * z;
        a = (z < 0) ? -z : z;
        if (a >= 5 * one)          y = one;
        else if (8 * a >= 19 * one) y = a / 32 + (27 * one) / 32;
        else if (a >= one)         y = a / 8 + (5 * one) / 8;
        else                       y = a / 4 + one / 2;
        sig = (z < 0) ? one - y : y;
        res = m ? 2 * sig - one : sig;
        return res[31:0];
    endfunction

    task automatic do_op(input logic [31:0] x, input logic m, input int hold,
                         input logic [31:0] exp, input string tag);
        int          cyc;
        logic [31:0] held;
        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        bus.mode     = m;
        @(posedge clk); #1;
        // noise while busy must not be captured
        bus.x_in      = $urandom;
        bus.mode      = 1'($urandom);
        bus.out_ready = (hold == 0);
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        cyc = 0;
        while (cyc < 12) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            cyc++;
            if (bus.out_valid) break;
        end
        // accepting edge plus four more: valid after the fifth posedge
        check({tag, "_lat"}, 32'(cyc), 32'd4);
        check({tag, "_out"}, bus.out, exp);
        held = bus.out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, bus.out, held);
            check({tag, "_hvld"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hrdy"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_free"}, 32'(bus.in_ready), 32'd1);
    endtask

    logic [31:0] edges [10] = '{
        32'h0001_0000, 32'h0000_FFFF, 32'h0002_6000, 32'h0002_5FFF,
        32'h0005_0000, 32'h0004_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
        32'hC000_0000, 32'h0000_8000
    };

    initial begin
        logic [31:0] x;
        logic        m;
        logic        seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_in      = '0;
        bus.mode      = 1'b0;

        @(posedge clk); #1;
        check("rst_rdy", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        check("rst_vld", 32'(bus.out_valid), 32'd0);
        check("rst_out", bus.out, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_rel", 32'(bus.in_ready), 32'd1);

        do_op(32'h0000_0000, 1'b0, 0, 32'h0000_8000, "sig0");
        do_op(32'h0000_0000, 1'b1, 0, 32'h0000_0000, "tanh0");
        do_op(32'h0001_0000, 1'b1, 3, 32'h0000_C000, "tanh1");
        do_op(32'hFFFD_0000, 1'b0, 0, 32'h0000_1000, "sigm3");
        do_op(32'h0005_0000, 1'b0, 0, 32'h0001_0000, "sig5");
        do_op(32'hFFFC_0000, 1'b1, 1, 32'hFFFF_0000, "tanhm4");
        do_op(32'h8000_0000, 1'b0, 0, 32'h0000_0000, "sigmin");
        do_op(32'h7FFF_FFFF, 1'b1, 0, 32'h0001_0000, "tanhovf");

        // reset while the op sits in SEG
        bus.in_valid = 1'b1;
        bus.x_in     = 32'h0001_0000;
        bus.mode     = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rmid_rdy", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rmid_vld", 32'(bus.out_valid), 32'd0);
        check("rmid_out", bus.out, 32'd0);
        #1;
        check("rmid_idle", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        bus.out_ready = 1'b0;
        check("rmid_stale", 32'(seen), 32'd0);

        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 3))
                0: x = $urandom;
                1: x = 32'($urandom_range(0, 14 * 65536)) - 32'(7 * 65536);
                2: begin
                    x = edges[$urandom_range(0, 9)];
                    if ($urandom_range(0, 1) == 1) x = -x;
                end
                default: x = 32'($urandom_range(0, 65535)) - 32'd32768;
            endcase
            m = 1'($urandom);
            do_op(x, m, int'($urandom_range(0, 3)), model(x, m), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
